// File: rtl/vtg_pkg.sv
// Shared types, default 1080p timing and sizing helper for the video timing generator.
package vtg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } vtg_state_e;

    localparam int VTG_H_ACTIVE = 1920;
    localparam int VTG_H_FP     = 88;
    localparam int VTG_H_SYNC   = 44;
    localparam int VTG_H_BP     = 148;
    localparam int VTG_V_ACTIVE = 1080;
    localparam int VTG_V_FP     = 4;
    localparam int VTG_V_SYNC   = 5;
    localparam int VTG_V_BP     = 36;

    localparam int VTG_COORD_W  = 23;
    localparam int VTG_LINE_W   = 11;

    function automatic int vtg_cnt_width(input int total);
        if (total > 1) begin
            return $clog2(total);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Run request, status and raster strobes between the timing generator and the pattern path.
interface video_timing_gen_if;
    import vtg_pkg::*;

    logic                   en;
    logic                   busy;
    logic [VTG_COORD_W-1:0] coord;
    logic [VTG_LINE_W-1:0]  line_y;
    logic                   de;
    logic                   hsync;
    logic                   vsync;
    logic                   frame_start;
    logic                   de_lut;
    logic                   hsync_lut;
    logic                   vsync_lut;

    modport master (
        input  en,
        output busy, coord, line_y, de, hsync, vsync, frame_start,
               de_lut, hsync_lut, vsync_lut
    );

    modport slave (
        output en,
        input  busy, coord, line_y, de, hsync, vsync, frame_start,
               de_lut, hsync_lut, vsync_lut
    );

endinterface

// File: rtl/vtg_axis_counter.sv
// One raster axis: position counter with wrap, plus active/sync decode of the next position.
module vtg_axis_counter
    import vtg_pkg::*;
#(
    parameter int ACTIVE = VTG_H_ACTIVE,
    parameter int FP     = VTG_H_FP,
    parameter int SYNC   = VTG_H_SYNC,
    parameter int BP     = VTG_H_BP,
    parameter int W      = vtg_cnt_width(ACTIVE + FP + SYNC + BP)
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic         last_o,
    output logic [W-1:0] nxt_o,
    output logic         active_o,
    output logic         sync_o
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign last_o = (cnt_q == W'(TOTAL - 1));

    // Next position: clear wins, otherwise step and wrap at the end of the axis.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            if (last_o) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign nxt_o    = cnt_d;
    assign active_o = (cnt_d < W'(ACTIVE));
    assign sync_o   = (cnt_d >= W'(ACTIVE + FP)) && (cnt_d < W'(ACTIVE + FP + SYNC));

    // Position register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator with frame-boundary start/stop. Outputs are decoded from the
// next raster position and registered. VTG_LUT_ALIGN_EN delays the *_lut strobes by one clock.
module video_timing_gen
    import vtg_pkg::*;
#(
    parameter int H_ACTIVE = VTG_H_ACTIVE,
    parameter int H_FP     = VTG_H_FP,
    parameter int H_SYNC   = VTG_H_SYNC,
    parameter int H_BP     = VTG_H_BP,
    parameter int V_ACTIVE = VTG_V_ACTIVE,
    parameter int V_FP     = VTG_V_FP,
    parameter int V_SYNC   = VTG_V_SYNC,
    parameter int V_BP     = VTG_V_BP
) (
    input  logic                clk,
    input  logic                rstn,
    video_timing_gen_if.master  vif
);

    localparam int HW = vtg_cnt_width(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VW = vtg_cnt_width(V_ACTIVE + V_FP + V_SYNC + V_BP);

    vtg_state_e state_q, state_d;

    logic          cnt_clr_s;
    logic          h_last_s, v_last_s, frame_last_s;
    logic [HW-1:0] h_nxt_s;
    logic [VW-1:0] v_nxt_s;
    logic          h_act_s, v_act_s, h_sync_s, v_sync_s;
    logic          run_d, de_d, hs_d, vs_d, fs_d;
    logic [VTG_COORD_W-1:0] coord_d;
    logic [VTG_LINE_W-1:0]  line_d;

    logic          busy_q, de_q, hs_q, vs_q, fs_q;
    logic [VTG_COORD_W-1:0] coord_q;
    logic [VTG_LINE_W-1:0]  line_q;

    assign frame_last_s = h_last_s && v_last_s;

    // Run control: stopping is only honoured on the last pixel of a frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (vif.en) state_d = RUN;
                else        state_d = IDLE;
            end
            RUN: begin
                if (vif.en)            state_d = RUN;
                else if (frame_last_s) state_d = IDLE;
                else                   state_d = DRAIN;
            end
            DRAIN: begin
                if (vif.en)            state_d = RUN;
                else if (frame_last_s) state_d = IDLE;
                else                   state_d = DRAIN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Counters sit at 0 in IDLE, and the first running cycle shows position 0,0.
    assign cnt_clr_s = (state_q == IDLE) || (state_d == IDLE);

    vtg_axis_counter #(
        .ACTIVE (H_ACTIVE), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP), .W (HW)
    ) u_h_cnt (
        .clk      (clk),
        .rstn     (rstn),
        .clr_i    (cnt_clr_s),
        .inc_i    (1'b1),
        .last_o   (h_last_s),
        .nxt_o    (h_nxt_s),
        .active_o (h_act_s),
        .sync_o   (h_sync_s)
    );

    vtg_axis_counter #(
        .ACTIVE (V_ACTIVE), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP), .W (VW)
    ) u_v_cnt (
        .clk      (clk),
        .rstn     (rstn),
        .clr_i    (cnt_clr_s),
        .inc_i    (h_last_s),
        .last_o   (v_last_s),
        .nxt_o    (v_nxt_s),
        .active_o (v_act_s),
        .sync_o   (v_sync_s)
    );

    // Output decode of the upcoming position; coordinates are forced to 0 outside active video.
    always_comb begin
        run_d   = (state_d != IDLE);
        de_d    = run_d && h_act_s && v_act_s;
        hs_d    = run_d && h_sync_s;
        vs_d    = run_d && v_sync_s;
        fs_d    = run_d && (h_nxt_s == '0) && (v_nxt_s == '0);
        coord_d = '0;
        line_d  = '0;
        if (de_d) begin
            coord_d = VTG_COORD_W'(h_nxt_s);
            line_d  = VTG_LINE_W'(v_nxt_s);
        end else begin
            coord_d = '0;
            line_d  = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            de_q    <= 1'b0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            fs_q    <= 1'b0;
            coord_q <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= run_d;
            de_q    <= de_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            fs_q    <= fs_d;
            coord_q <= coord_d;
            line_q  <= line_d;
        end
    end

    assign vif.busy        = busy_q;
    assign vif.de          = de_q;
    assign vif.hsync       = hs_q;
    assign vif.vsync       = vs_q;
    assign vif.frame_start = fs_q;
    assign vif.coord       = coord_q;
    assign vif.line_y      = line_q;

`ifdef VTG_LUT_ALIGN_EN
    logic de_lut_q, hs_lut_q, vs_lut_q;

    // One-clock strobe delay matching the registered LUT downstream.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            de_lut_q <= 1'b0;
            hs_lut_q <= 1'b0;
            vs_lut_q <= 1'b0;
        end else begin
            de_lut_q <= de_q;
            hs_lut_q <= hs_q;
            vs_lut_q <= vs_q;
        end
    end

    assign vif.de_lut    = de_lut_q;
    assign vif.hsync_lut = hs_lut_q;
    assign vif.vsync_lut = vs_lut_q;
`else
    assign vif.de_lut    = de_q;
    assign vif.hsync_lut = hs_q;
    assign vif.vsync_lut = vs_q;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a 14x7 raster: vector table plus multi-cycle sequences.
module tb_video_timing_gen;
    import vtg_pkg::*;

    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    video_timing_gen_if vif();

    video_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .vif  (vif)
    );

    typedef struct packed {
        logic        busy, de, hs, vs, fs, dl, hl, vl;
        logic [22:0] coord;
        logic [10:0] line;
    } out_t;

    typedef struct {
        logic rstn;
        logic en;
        out_t exp;
    } vec_t;

    int total = 0;
    int bad   = 0;

    out_t obs;
    assign obs = {vif.busy, vif.de, vif.hsync, vif.vsync, vif.frame_start,
                  vif.de_lut, vif.hsync_lut, vif.vsync_lut, vif.coord, vif.line_y};

`ifdef VTG_LUT_ALIGN_EN
    logic [7:0] gray_q;
    always @(posedge clk) gray_q <= 8'((32'(vif.coord) * 255) / (HA - 1));
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input out_t exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s t=%0t: got %h expected %h", name, $time, obs, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic out_t mk(input bit busy, input bit de, input bit hs, input bit vs,
                                input bit fs, input int coord, input int line);
        out_t o;
        o = '0;
        o.busy = busy; o.de = de; o.hs = hs; o.vs = vs; o.fs = fs;
        o.coord = 23'(coord);
        o.line  = 11'(line);
        return o;
    endfunction

    // Fill in the *_lut fields: delayed copy with the align macro, same-cycle copy without.
    function automatic out_t with_lut(input out_t cur, input out_t prev);
        out_t o;
        o = cur;
`ifdef VTG_LUT_ALIGN_EN
        o.dl = prev.de; o.hl = prev.hs; o.vl = prev.vs;
`else
        o.dl = cur.de;  o.hl = cur.hs;  o.vl = cur.vs;
`endif
        return o;
    endfunction

    // Expected raster output t clocks after a frame started, from elapsed time alone.
    function automatic out_t exp_at(input int t);
        int h, v;
        bit de;
        h  = t % HT;
        v  = (t / HT) % VT;
        de = (h < HA) && (v < VA);
        return mk(1'b1, de, (h >= HA + HF) && (h < HA + HF + HS),
                  (v >= VA + VF) && (v < VA + VF + VS), (h == 0) && (v == 0),
                  de ? h : 0, de ? v : 0);
    endfunction

    task automatic go_idle();
        rstn = 1'b0; vif.en = 1'b0; step();
        rstn = 1'b1; step();
    endtask

    // Start from IDLE, toggle en at the given frame times, and expect a clean stop afterwards.
    task automatic run_check(input string name, input int ncyc, input int drop_at,
                             input int raise_at, input int drop2_at);
        out_t prev, cur;
        vif.en = 1'b1;
        step();
        prev = '0;
        for (int t = 0; t < ncyc; t++) begin
            cur = exp_at(t);
            check($sformatf("%s_t%0d", name, t), with_lut(cur, prev));
            prev = cur;
            if (t == drop_at || t == drop2_at) vif.en = 1'b0;
            else if (t == raise_at)            vif.en = 1'b1;
            step();
        end
        check({name, "_end"}, with_lut('0, prev));
        step();
        check({name, "_flush"}, '0);
    endtask

    vec_t tbl[21];

    initial begin
        out_t prev, e;
        int n, first, last;

        rstn = 1'b0;
        vif.en = 1'b0;
        repeat (3) step();
        check("reset", '0);

        tbl[0] = '{1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0, 0)};
        tbl[1] = '{1'b1, 1'b1, mk(1, 1, 0, 0, 1, 0, 0)};
        for (int i = 2; i <= 8; i++) tbl[i] = '{1'b1, 1'b1, mk(1, 1, 0, 0, 0, i - 1, 0)};
        tbl[9]  = '{1'b1, 1'b1, mk(1, 0, 0, 0, 0, 0, 0)};
        tbl[10] = '{1'b1, 1'b1, mk(1, 0, 0, 0, 0, 0, 0)};
        tbl[11] = '{1'b1, 1'b1, mk(1, 0, 1, 0, 0, 0, 0)};
        tbl[12] = '{1'b1, 1'b1, mk(1, 0, 1, 0, 0, 0, 0)};
        tbl[13] = '{1'b1, 1'b1, mk(1, 0, 0, 0, 0, 0, 0)};
        tbl[14] = '{1'b1, 1'b1, mk(1, 0, 0, 0, 0, 0, 0)};
        tbl[15] = '{1'b1, 1'b1, mk(1, 1, 0, 0, 0, 0, 1)};
        tbl[16] = '{1'b1, 1'b1, mk(1, 1, 0, 0, 0, 1, 1)};
        tbl[17] = '{1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0, 0)};
        tbl[18] = '{1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0, 0)};
        tbl[19] = '{1'b1, 1'b1, mk(1, 1, 0, 0, 1, 0, 0)};
        tbl[20] = '{1'b1, 1'b0, mk(1, 1, 0, 0, 0, 1, 0)};

        prev = '0;
        for (int i = 0; i < 21; i++) begin
            rstn   = tbl[i].rstn;
            vif.en = tbl[i].en;
            step();
            e = tbl[i].rstn ? with_lut(tbl[i].exp, prev) : tbl[i].exp;
            check($sformatf("vec%0d", i), e);
            prev = tbl[i].exp;
        end
        go_idle();

        run_check("cont", 3 * HT * VT, -1, -1, 2 * HT * VT);
        run_check("drain", HT * VT, HT + 3, -1, -1);
        run_check("lastpix", HT * VT, HT * VT - 1, -1, -1);
        run_check("redrain", 2 * HT * VT, 20, 40, 100);
        run_check("raise_last", 2 * HT * VT, 50, HT * VT - 1, 100);

        vif.en = 1'b1;
        step();
        repeat (2 * HT + 5) step();
        check("pre_rst", with_lut(exp_at(2 * HT + 5), exp_at(2 * HT + 4)));
        rstn = 1'b0;
        step();
        check("midrst", '0);
        rstn = 1'b1;
        step();
        check("restart", with_lut(exp_at(0), '0));
        step();
        check("restart_t1", with_lut(exp_at(1), exp_at(0)));
        go_idle();

`ifdef VTG_LUT_ALIGN_EN
        vif.en = 1'b1;
        step();
        n = 0; first = -1; last = -1;
        for (int k = 0; k < HT; k++) begin
            if (vif.de_lut) begin
                if (n == 0) first = int'(gray_q);
                last = int'(gray_q);
                n++;
            end
            step();
        end
        check_int("ramp_len", n, HA);
        check_int("ramp_first", first, 0);
        check_int("ramp_last", last, 255);
        go_idle();
`else
        n = 0; first = 0; last = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
